// File: rtl/kgp_isa_pkg.sv
// ---------------------------------------------------------------------------
// kgp_isa_pkg
//   Shared ISA constants for the branch unit and its neighbours.
//   Every branch-class opcode is {BR_CLASS, fcode}. CALL and RET are
//   built from their fcodes, so the two encodings cannot drift apart.
// ---------------------------------------------------------------------------
package kgp_isa_pkg;

  localparam logic [1:0] BR_CLASS = 2'b11;

  // Branch-unit function codes (low four bits of a branch-class opcode)
  localparam logic [3:0] FC_JMP  = 4'b0000;
  localparam logic [3:0] FC_BEQ  = 4'b0001;
  localparam logic [3:0] FC_BNE  = 4'b0010;
  localparam logic [3:0] FC_CALL = 4'b1001;
  localparam logic [3:0] FC_RET  = 4'b1110;

  localparam logic [5:0] OP_CALL = {BR_CLASS, FC_CALL};  // 6'b111001
  localparam logic [5:0] OP_RET  = {BR_CLASS, FC_RET};   // 6'b111110

endpackage

// File: rtl/ras_regfile.sv
// ---------------------------------------------------------------------------
// ras_regfile
//   DEPTH x AW storage for the return address stack.
//   It has one synchronous write port and one asynchronous read port.
//   Contents are not reset: the stack pointer and count decide which
//   entries hold meaningful data.
// Ports
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index
//   rdata  out  mem[raddr], combinational
// ---------------------------------------------------------------------------
module ras_regfile #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [AW-1:0] rdata
);

  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// ---------------------------------------------------------------------------
// return_addr_stack
//   Circular LIFO of return addresses that sits beside the EX-stage branch
//   unit. A CALL pushes pc+1 and a RET pops it. The top entry is read
//   combinationally from registered state, so a RET can steer the next PC
//   in its own cycle. Pushes and pops become visible one cycle after their
//   edge, and a value being pushed is never bypassed to the output.
// Ports
//   clk, rst   clock; synchronous active-high reset
//   en         EX instruction valid and not stalled. A plain qualifier:
//              opcode acts only in a cycle with en=1. There is no
//              back-pressure, so every qualified CALL/RET is accepted.
//   opcode     EX-stage opcode
//   pc         PC of the EX-stage instruction
//   flush      drop all entries; wins over a push/pop in the same cycle
//   top_addr   top entry (0 when empty)
//   top_valid  stack non-empty
//   count      valid entries, 0..DEPTH
//   full       count == DEPTH
//   ovf        sticky: a push overwrote the oldest entry
//   unf        sticky: a RET was executed on an empty stack
// ---------------------------------------------------------------------------
module return_addr_stack
  import kgp_isa_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [5:0]    opcode,
  input  logic [AW-1:0] pc,
  input  logic          flush,
  output logic [AW-1:0] top_addr,
  output logic          top_valid,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  logic [PW-1:0] sp_q, sp_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          push, pop, is_full, is_empty;
  logic          mem_we;
  logic [PW-1:0] rd_idx;
  logic [AW-1:0] rd_data;

  assign push     = en && (opcode == OP_CALL);
  assign pop      = en && (opcode == OP_RET);
  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);

  // The push slot is sp itself, so the top of stack is the slot just below.
  // The subtraction wraps modulo DEPTH on purpose.
  assign rd_idx = sp_q - PW'(1);

  // A write is suppressed when flush or rst wins the cycle. The slot would be
  // invisible anyway, but this keeps the array free of dropped pushes.
  assign mem_we = push && !flush && !rst;

  ras_regfile #(.DEPTH(DEPTH), .AW(AW)) u_regfile (
    .clk   (clk),
    .we    (mem_we),
    .waddr (sp_q),
    .wdata (pc + AW'(1)),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (flush) begin
      sp_d    = '0;
      count_d = '0;
    end else if (push) begin
      sp_d = sp_q + PW'(1);
      // When the stack is full, the push lands on the oldest entry and the
      // count saturates.
      if (is_full) ovf_d   = 1'b1;
      else         count_d = count_q + CW'(1);
    end else if (pop) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else begin
        sp_d    = sp_q - PW'(1);
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign top_valid = !is_empty;
  assign top_addr  = top_valid ? rd_data : '0;
  assign count     = count_q;
  assign full      = is_full;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_return_addr_stack.sv
module tb_return_addr_stack;
  import kgp_isa_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = AW + 1 + CW + 3;
  localparam logic [5:0] OP_NOP = 6'b000000;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [5:0]    opcode = OP_NOP;
  logic [AW-1:0] pc = '0;
  logic          flush = 1'b0;
  logic [AW-1:0] top_addr;
  logic          top_valid;
  logic [CW-1:0] count;
  logic          full, ovf, unf;

  always #5 clk = ~clk;

  return_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .pc(pc), .flush(flush),
    .top_addr(top_addr), .top_valid(top_valid), .count(count),
    .full(full), .ovf(ovf), .unf(unf)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  // Then wait for the edge and compare at edge+1.
  task automatic step(input string name, input logic r, input logic e,
                      input logic [5:0] op, input logic [AW-1:0] p, input logic f,
                      input logic [AW-1:0] et, input logic etv, input logic [CW-1:0] ec,
                      input logic efull, input logic eovf, input logic eunf);
    logic [EW-1:0] x;
    rst = r; en = e; opcode = op; pc = p; flush = f;
    exp_q.push_back({et, etv, ec, efull, eovf, eunf});
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk({name, ".top_addr"},  top_addr,        x[EW-1 -: AW]);
    chk({name, ".top_valid"}, AW'(top_valid),  AW'(x[CW+3]));
    chk({name, ".count"},     AW'(count),      AW'(x[CW+2:3]));
    chk({name, ".full"},      AW'(full),       AW'(x[2]));
    chk({name, ".ovf"},       AW'(ovf),        AW'(x[1]));
    chk({name, ".unf"},       AW'(unf),        AW'(x[0]));
    rst = 1'b0; en = 1'b0; opcode = OP_NOP; flush = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic          rst, en;
    logic [5:0]    op;
    logic [AW-1:0] pc;
    logic          flush;
    logic [AW-1:0] top;
    logic          tv;
    logic [CW-1:0] cnt;
    logic          full, ovf, unf;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // rst en  op       pc            fl  top          tv cnt full ovf unf
    tbl.push_back('{1'b1, 1'b0, OP_NOP,  32'h0,        1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0}); // reset state
    tbl.push_back('{1'b0, 1'b1, OP_RET,  32'h40,       1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1}); // t1 empty ret
    tbl.push_back('{1'b1, 1'b0, OP_NOP,  32'h0,        1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0}); // clears unf
    tbl.push_back('{1'b0, 1'b1, OP_CALL, 32'h10,       1'b0, 32'h11, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0}); // t2
    tbl.push_back('{1'b0, 1'b1, OP_CALL, 32'h20,       1'b0, 32'h21, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, OP_CALL, 32'h30,       1'b0, 32'h31, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, OP_NOP,  32'h0,        1'b0, 32'h31, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0}); // hold
    tbl.push_back('{1'b0, 1'b1, OP_RET,  32'h0,        1'b0, 32'h21, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, OP_RET,  32'h0,        1'b0, 32'h11, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, OP_RET,  32'h0,        1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, OP_CALL, 32'h70,       1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0}); // t4 en=0
    tbl.push_back('{1'b0, 1'b1, 6'b111000, 32'h70,     1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0}); // near-CALL opcode
    tbl.push_back('{1'b0, 1'b1, OP_CALL, 32'hFFFFFFFF, 1'b0, 32'h0,  1'b1, 4'd1, 1'b0, 1'b0, 1'b0}); // pc+1 wraps
    tbl.push_back('{1'b0, 1'b1, OP_RET,  32'h0,        1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0});

    foreach (tbl[i])
      step($sformatf("tbl%0d", i), tbl[i].rst, tbl[i].en, tbl[i].op, tbl[i].pc, tbl[i].flush,
           tbl[i].top, tbl[i].tv, tbl[i].cnt, tbl[i].full, tbl[i].ovf, tbl[i].unf);

    // t3: overflow by two, then drain past empty
    step("t3.rst", 1'b1, 1'b0, OP_NOP, 0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH + 2; k++)
      step($sformatf("t3.call%0d", k), 1'b0, 1'b1, OP_CALL, AW'(k * 4), 1'b0,
           AW'(k * 4 + 1), 1'b1, (k + 1 < DEPTH) ? CW'(k + 1) : CW'(DEPTH),
           k >= DEPTH - 1, k >= DEPTH, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      step($sformatf("t3.ret%0d", i), 1'b0, 1'b1, OP_RET, 0, 1'b0,
           (i < DEPTH - 1) ? AW'(33 - 4 * i) : AW'(0), i < DEPTH - 1, CW'(DEPTH - 1 - i),
           1'b0, 1'b1, 1'b0);
    step("t3.unf", 1'b0, 1'b1, OP_RET, 0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);

    // t5: flush beats a simultaneous call; sticky flags survive it
    step("t5.rst",  1'b1, 1'b0, OP_NOP,  0,     1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step("t5.ret",  1'b0, 1'b1, OP_RET,  0,     1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step("t5.c10",  1'b0, 1'b1, OP_CALL, 'h10,  1'b0, 32'h11, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
    step("t5.c20",  1'b0, 1'b1, OP_CALL, 'h20,  1'b0, 32'h21, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
    step("t5.fl",   1'b0, 1'b1, OP_CALL, 'h50,  1'b1, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step("t5.ret2", 1'b0, 1'b1, OP_RET,  0,     1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step("t5.c60",  1'b0, 1'b1, OP_CALL, 'h60,  1'b0, 32'h61, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);

    // t6: reset with a return mid-sequence; reset also beats flush
    step("t6.ret",  1'b0, 1'b1, OP_RET,  0,     1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step("t6.ret0", 1'b0, 1'b1, OP_RET,  0,     1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++)
      step($sformatf("t6.call%0d", k), 1'b0, 1'b1, OP_CALL, AW'(32'h100 + k * 16), 1'b0,
           AW'(32'h101 + k * 16), 1'b1, CW'(k + 1), 1'b0, 1'b0, 1'b1);
    step("t6.rstret", 1'b1, 1'b1, OP_RET, 0,    1'b1, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step("t6.ret1",   1'b0, 1'b1, OP_RET, 0,    1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
